// File: rtl/full_logic_reader_pkg.sv
// Shared types and constants for the full_logic egress reader.
package full_logic_reader_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int CNT_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_CAPT  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    // Output register can take a new word this cycle.
    function automatic logic out_reg_free(input logic valid, input logic ready);
        return (!valid) || ready;
    endfunction

endpackage

// File: rtl/full_logic_reader_arb.sv
// Two-way round-robin selector: grants the FIFO not served last when both request.
module rr_arbiter_2
    import full_logic_reader_pkg::*;
(
    input  logic req_d0,
    input  logic req_d1,
    input  logic last,
    output logic grant,
    output logic sel
);

    // Grant/select decode from the requests and the last-served destination.
    always_comb begin
        grant = req_d0 | req_d1;
        sel   = DEST_D0;
        if (req_d0 && req_d1) begin
            sel = ~last;
        end else if (req_d1) begin
            sel = DEST_D1;
        end else begin
            sel = DEST_D0;
        end
    end

endmodule

// File: rtl/full_logic_reader.sv
// Drains D0/D1 destination FIFOs into one tagged valid/ready stream with
// round-robin arbitration, per-destination counters and a sticky error flag.
module full_logic_reader
    import full_logic_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic [DATA_WIDTH-1:0] data_out_D0,
    input  logic [DATA_WIDTH-1:0] data_out_D1,
    input  logic                  error_D0,
    input  logic                  error_D1,
    output logic                  D0_pop,
    output logic                  D1_pop,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  dest_out,
    output logic [CNT_WIDTH-1:0]  count_D0,
    output logic [CNT_WIDTH-1:0]  count_D1,
    output logic                  error_out
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  sel_q, sel_d;
    logic                  d0_pop_q, d0_pop_d;
    logic                  d1_pop_q, d1_pop_d;
    logic                  valid_q, valid_d;
    logic                  dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
    logic                  error_q, error_d;

    logic                  grant_s;
    logic                  arb_sel_s;
    logic                  err_in_s;
    logic                  free_s;

    rr_arbiter_2 u_arb (
        .req_d0 (~empty_fifo_D0),
        .req_d1 (~empty_fifo_D1),
        .last   (last_q),
        .grant  (grant_s),
        .sel    (arb_sel_s)
    );

    assign err_in_s = error_D0 | error_D1;
    assign free_s   = out_reg_free(valid_q, ready_in);

    // Next-state and pop decision; pops are registered so they line up with POP.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        d0_pop_d = 1'b0;
        d1_pop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (err_in_s || error_q) begin
                    state_d = ST_ERROR;
                end else if (enable && grant_s && free_s) begin
                    state_d  = ST_POP;
                    sel_d    = arb_sel_s;
                    last_d   = arb_sel_s;
                    d0_pop_d = (arb_sel_s == DEST_D0);
                    d1_pop_d = (arb_sel_s == DEST_D1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // The popped word is always captured, even if an error or a
            // disable arrives in this cycle.
            ST_POP: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                if (err_in_s || error_q) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register, saturating counters and sticky error.
    always_comb begin
        valid_d = valid_q & ~ready_in;
        data_d  = data_q;
        dest_d  = dest_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        error_d = error_q | err_in_s;
        if (state_q == ST_CAPT) begin
            valid_d = 1'b1;
            dest_d  = sel_q;
            if (sel_q == DEST_D1) begin
                data_d = data_out_D1;
                if (&cnt1_q) begin
                    cnt1_d = cnt1_q;
                end else begin
                    cnt1_d = cnt1_q + CNT_ONE;
                end
            end else begin
                data_d = data_out_D0;
                if (&cnt0_q) begin
                    cnt0_d = cnt0_q;
                end else begin
                    cnt0_d = cnt0_q + CNT_ONE;
                end
            end
        end else begin
            dest_d = dest_q;
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            sel_q    <= DEST_D0;
            d0_pop_q <= 1'b0;
            d1_pop_q <= 1'b0;
            valid_q  <= 1'b0;
            dest_q   <= DEST_D0;
            data_q   <= DATA_ZERO;
            cnt0_q   <= CNT_ZERO;
            cnt1_q   <= CNT_ZERO;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            d0_pop_q <= d0_pop_d;
            d1_pop_q <= d1_pop_d;
            valid_q  <= valid_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            error_q  <= error_d;
        end
    end

    assign D0_pop    = d0_pop_q;
    assign D1_pop    = d1_pop_q;
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign dest_out  = dest_q;
    assign count_D0  = cnt0_q;
    assign count_D1  = cnt1_q;
    assign error_out = error_q;

endmodule
